// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone width down-converter.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT,
    ST_ACK,
    ST_ERR
  } state_e;

  // Beat-index width; a 1:1 ratio still keeps a 1-bit index.
  function automatic int beat_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Big-endian: beat 0 occupies the most significant lane.
  function automatic int lane_of(input int ratio, input int beat);
    return ratio - 1 - beat;
  endfunction

endpackage

// File: rtl/wb_width_downsizer_timeout.sv
// Loadable down-counter bounding the wait for a beat acknowledge.
module wb_timeout_ctr #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  // Loading TIMEOUT_CYC-1 makes the TIMEOUT_CYC-th beat cycle the expiry cycle.
  localparam logic [CW-1:0] LOAD_V = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_V;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (TIMEOUT_CYC != 0) && (cnt_q == '0);

endmodule

// File: rtl/wb_width_downsizer.sv
// Wishbone classic width down-converter: one wide slave access becomes
// up to S_DW/M_DW narrow master beats, skipping lanes with no byte selects.
module wb_width_downsizer
  import wb_pkg::*;
#(
  parameter int S_DW        = 32,
  parameter int M_DW        = 16,
  parameter int AW          = 21,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [AW-1:0]                      s_adr_i,
  input  logic [S_DW-1:0]                    s_dat_i,
  output logic [S_DW-1:0]                    s_dat_o,
  input  logic [S_DW/8-1:0]                  s_sel_i,
  input  logic                               s_we_i,
  input  logic                               s_stb_i,
  input  logic                               s_cyc_i,
  output logic                               s_ack_o,
  output logic                               s_err_o,
  output logic [AW+$clog2(S_DW/M_DW)-1:0]    m_adr_o,
  output logic [M_DW-1:0]                    m_dat_o,
  input  logic [M_DW-1:0]                    m_dat_i,
  output logic [M_DW/8-1:0]                  m_sel_o,
  output logic                               m_we_o,
  output logic                               m_stb_o,
  output logic                               m_cyc_o,
  input  logic                               m_ack_i
);

  localparam int RATIO = S_DW / M_DW;
  localparam int BW    = beat_w(RATIO);
  localparam int MSW   = M_DW / 8;

  state_e                     state_q;
  logic [AW-1:0]              adr_q;
  logic [RATIO-1:0][M_DW-1:0] dat_q;
  logic [RATIO-1:0][M_DW-1:0] rbuf_q;
  logic [RATIO-1:0][MSW-1:0]  sel_q;
  logic [RATIO-1:0][MSW-1:0]  sel_in;
  logic                       we_q;
  logic [BW-1:0]              beat_q;
  logic [BW-1:0]              first_k;
  logic [BW-1:0]              next_k;
  logic [BW-1:0]              lane_idx;
  logic [RATIO-1:0]           grp_nz_in;
  logic [RATIO-1:0]           grp_nz_q;
  logic                       first_vld;
  logic                       next_vld;
  logic                       in_beat;
  logic                       accept;
  logic                       tmo_load;
  logic                       tmo_exp;

  assign sel_in = s_sel_i;

  for (genvar g = 0; g < RATIO; g++) begin : g_grp
    assign grp_nz_in[g] = |sel_in[lane_of(RATIO, g)];
    assign grp_nz_q[g]  = |sel_q[lane_of(RATIO, g)];
  end

  // Lowest-numbered active beat, and the next active beat after beat_q.
  always_comb begin
    first_vld = 1'b0;
    first_k   = '0;
    next_vld  = 1'b0;
    next_k    = '0;
    for (int k = RATIO - 1; k >= 0; k--) begin
      if (grp_nz_in[k]) begin
        first_vld = 1'b1;
        first_k   = BW'(k);
      end
      if (grp_nz_q[k] && (k > int'(beat_q))) begin
        next_vld = 1'b1;
        next_k   = BW'(k);
      end
    end
  end

  assign in_beat  = (state_q == ST_BEAT);
  assign accept   = (state_q == ST_IDLE) && s_cyc_i && s_stb_i;
  assign tmo_load = (accept && first_vld) || (in_beat && s_cyc_i && m_ack_i && next_vld);
  assign lane_idx = BW'(RATIO - 1) - beat_q;

  wb_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (tmo_load),
    .dec_i    (in_beat),
    .expired_o(tmo_exp)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      beat_q  <= '0;
      rbuf_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            adr_q  <= s_adr_i;
            dat_q  <= s_dat_i;
            sel_q  <= s_sel_i;
            we_q   <= s_we_i;
            rbuf_q <= '0;
            beat_q <= first_k;
            state_q <= first_vld ? ST_BEAT : ST_ACK;
          end
        end
        ST_BEAT: begin
          // Abort beats a same-cycle ack; an ack beats a same-cycle expiry.
          if (!s_cyc_i) begin
            state_q <= ST_IDLE;
          end else if (m_ack_i) begin
            if (!we_q) begin
              rbuf_q[lane_idx] <= m_dat_i;
            end
            if (next_vld) begin
              beat_q <= next_k;
            end else begin
              state_q <= ST_ACK;
            end
          end else if (tmo_exp) begin
            state_q <= ST_ERR;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  if (RATIO > 1) begin : g_adr_wide
    assign m_adr_o = in_beat ? {adr_q, beat_q} : '0;
  end else begin : g_adr_pass
    assign m_adr_o = in_beat ? adr_q : '0;
  end

  assign m_cyc_o = in_beat;
  assign m_stb_o = in_beat;
  assign m_we_o  = in_beat && we_q;
  assign m_dat_o = in_beat ? dat_q[lane_idx] : '0;
  assign m_sel_o = in_beat ? sel_q[lane_idx] : '0;
  assign s_ack_o = (state_q == ST_ACK);
  assign s_err_o = (state_q == ST_ERR);
  assign s_dat_o = (state_q == ST_ACK) ? rbuf_q : '0;

endmodule

// File: tb/tb_wb_width_downsizer.sv
// Directed bench: a 32->16 instance with a short timeout and a 32->8 instance.
module tb_wb_width_downsizer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A: 32 -> 16, TIMEOUT_CYC = 4
  logic [20:0] a_adr;
  logic [31:0] a_sdat_i, a_sdat_o;
  logic [3:0]  a_ssel;
  logic        a_we, a_stb, a_cyc, a_sack, a_serr;
  logic [21:0] a_madr;
  logic [15:0] a_mdat_o, a_mdat_i;
  logic [1:0]  a_msel;
  logic        a_mwe, a_mstb, a_mcyc, a_mack;
  logic        a_auto, a_man_ack;
  logic [15:0] a_man_dat;

  assign a_mack   = a_auto ? a_mstb : (a_man_ack & a_mstb);
  assign a_mdat_i = a_auto ? (a_madr[0] ? 16'h1234 : 16'hABCD) : a_man_dat;

  wb_width_downsizer #(.S_DW(32), .M_DW(16), .AW(21), .TIMEOUT_CYC(4)) u_a (
    .clk_i(clk), .rst_i(rst),
    .s_adr_i(a_adr), .s_dat_i(a_sdat_i), .s_dat_o(a_sdat_o), .s_sel_i(a_ssel),
    .s_we_i(a_we), .s_stb_i(a_stb), .s_cyc_i(a_cyc), .s_ack_o(a_sack), .s_err_o(a_serr),
    .m_adr_o(a_madr), .m_dat_o(a_mdat_o), .m_dat_i(a_mdat_i), .m_sel_o(a_msel),
    .m_we_o(a_mwe), .m_stb_o(a_mstb), .m_cyc_o(a_mcyc), .m_ack_i(a_mack)
  );

  // Instance B: 32 -> 8, zero-wait slave
  logic [20:0] b_adr;
  logic [31:0] b_sdat_i, b_sdat_o;
  logic [3:0]  b_ssel;
  logic        b_we, b_stb, b_cyc, b_sack, b_serr;
  logic [22:0] b_madr;
  logic [7:0]  b_mdat_o, b_mdat_i;
  logic        b_msel;
  logic        b_mwe, b_mstb, b_mcyc, b_mack;

  assign b_mack   = b_mstb;
  assign b_mdat_i = (b_madr[1:0] == 2'd0) ? 8'hAA : (b_madr[1:0] == 2'd3) ? 8'hBB : 8'h77;

  wb_width_downsizer #(.S_DW(32), .M_DW(8), .AW(21), .TIMEOUT_CYC(255)) u_b (
    .clk_i(clk), .rst_i(rst),
    .s_adr_i(b_adr), .s_dat_i(b_sdat_i), .s_dat_o(b_sdat_o), .s_sel_i(b_ssel),
    .s_we_i(b_we), .s_stb_i(b_stb), .s_cyc_i(b_cyc), .s_ack_o(b_sack), .s_err_o(b_serr),
    .m_adr_o(b_madr), .m_dat_o(b_mdat_o), .m_dat_i(b_mdat_i), .m_sel_o(b_msel),
    .m_we_o(b_mwe), .m_stb_o(b_mstb), .m_cyc_o(b_mcyc), .m_ack_i(b_mack)
  );

  task automatic req_a(input logic [20:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we);
    a_adr = adr; a_sdat_i = dat; a_ssel = sel; a_we = we; a_cyc = 1'b1; a_stb = 1'b1;
  endtask

  task automatic drop_a();
    a_cyc = 1'b0; a_stb = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({a_sack, a_serr, a_mcyc, a_mstb, a_mwe} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctl: got %b want 00000", {a_sack, a_serr, a_mcyc, a_mstb, a_mwe});
    end
    n_cmp++;
    if ({a_madr, a_mdat_o, a_msel, a_sdat_o} !== 72'h0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", {a_madr, a_mdat_o, a_msel, a_sdat_o});
    end
    n_cmp++;
    if ({b_sack, b_mcyc, b_madr} !== 25'h0) begin
      n_bad++; $display("FAIL reset_b: got %h want 0", {b_sack, b_mcyc, b_madr});
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    a_auto = 1'b1;
    req_a(21'h00010, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (a_madr !== 22'h00020 || a_mstb !== 1'b1 || a_msel !== 2'b11 || a_sack !== 1'b0) begin
      n_bad++; $display("FAIL rd_beat0: got adr=%h stb=%b sel=%b ack=%b want 00020 1 11 0", a_madr, a_mstb, a_msel, a_sack);
    end
    @(negedge clk);
    n_cmp++;
    if (a_madr !== 22'h00021 || a_mstb !== 1'b1 || a_sack !== 1'b0) begin
      n_bad++; $display("FAIL rd_beat1: got adr=%h stb=%b ack=%b want 00021 1 0", a_madr, a_mstb, a_sack);
    end
    @(negedge clk);
    n_cmp++;
    if (a_sack !== 1'b1 || a_sdat_o !== 32'hABCD1234 || a_mcyc !== 1'b0) begin
      n_bad++; $display("FAIL rd_ack: got ack=%b dat=%h cyc=%b want 1 abcd1234 0", a_sack, a_sdat_o, a_mcyc);
    end
    drop_a();
    @(negedge clk);
  endtask

  task automatic test_write();
    a_auto = 1'b1;
    req_a(21'h00010, 32'hDEADBEEF, 4'b0011, 1'b1);
    @(negedge clk);
    a_sdat_i = 32'h11111111; a_ssel = 4'hF;
    n_cmp++;
    if (a_madr !== 22'h00021 || a_mdat_o !== 16'hBEEF || a_msel !== 2'b11 || a_mwe !== 1'b1 || a_mstb !== 1'b1) begin
      n_bad++; $display("FAIL wr_beat: got adr=%h dat=%h sel=%b we=%b stb=%b want 00021 beef 11 1 1",
                        a_madr, a_mdat_o, a_msel, a_mwe, a_mstb);
    end
    @(negedge clk);
    n_cmp++;
    if (a_sack !== 1'b1 || a_mcyc !== 1'b0 || a_sdat_o !== 32'h0) begin
      n_bad++; $display("FAIL wr_ack: got ack=%b cyc=%b dat=%h want 1 0 0", a_sack, a_mcyc, a_sdat_o);
    end
    drop_a();
    @(negedge clk);
    n_cmp++;
    if (a_sack !== 1'b0 || a_mcyc !== 1'b0) begin
      n_bad++; $display("FAIL wr_after: got ack=%b cyc=%b want 0 0", a_sack, a_mcyc);
    end
  endtask

  task automatic test_timeout();
    int errs, acks, stbs, err_cyc, both;
    errs = 0; acks = 0; stbs = 0; err_cyc = 0; both = 0;
    a_auto = 1'b0; a_man_ack = 1'b0; a_man_dat = 16'h0;
    req_a(21'h00005, 32'h0, 4'hF, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (a_serr) begin errs++; err_cyc = c; end
      if (a_sack) acks++;
      if (a_mstb) stbs++;
      if (a_sack && a_serr) both++;
      if (c == 5) drop_a();
    end
    n_cmp++;
    if (errs != 1 || err_cyc != 5) begin
      n_bad++; $display("FAIL tmo_err: got pulses=%0d cycle=%0d want 1 5", errs, err_cyc);
    end
    n_cmp++;
    if (acks != 0 || both != 0) begin
      n_bad++; $display("FAIL tmo_noack: got acks=%0d both=%0d want 0 0", acks, both);
    end
    n_cmp++;
    if (stbs != 4 || a_mcyc !== 1'b0) begin
      n_bad++; $display("FAIL tmo_stb: got stb_cycles=%0d cyc=%b want 4 0", stbs, a_mcyc);
    end
  endtask

  task automatic test_expiry_ack();
    a_auto = 1'b0; a_man_ack = 1'b0;
    req_a(21'h00007, 32'h0, 4'b0011, 1'b0);
    @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk);
    n_cmp++;
    if (a_mstb !== 1'b1 || a_serr !== 1'b0 || a_madr !== 22'h0000F) begin
      n_bad++; $display("FAIL exp_wait: got stb=%b err=%b adr=%h want 1 0 0000f", a_mstb, a_serr, a_madr);
    end
    a_man_ack = 1'b1; a_man_dat = 16'h5A5A;
    @(negedge clk);
    a_man_ack = 1'b0;
    n_cmp++;
    if (a_sack !== 1'b1 || a_serr !== 1'b0 || a_sdat_o !== 32'h00005A5A) begin
      n_bad++; $display("FAIL exp_ack: got ack=%b err=%b dat=%h want 1 0 00005a5a", a_sack, a_serr, a_sdat_o);
    end
    drop_a();
    @(negedge clk);
    n_cmp++;
    if (a_serr !== 1'b0 || a_sack !== 1'b0) begin
      n_bad++; $display("FAIL exp_after: got err=%b ack=%b want 0 0", a_serr, a_sack);
    end
  endtask

  task automatic test_abort();
    int acks, errs, cycs;
    acks = 0; errs = 0; cycs = 0;
    a_auto = 1'b0; a_man_ack = 1'b0;
    req_a(21'h00009, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (a_madr !== 22'h00012 || a_mstb !== 1'b1) begin
      n_bad++; $display("FAIL abort_beat0: got adr=%h stb=%b want 00012 1", a_madr, a_mstb);
    end
    a_man_ack = 1'b1; a_man_dat = 16'h1111;
    @(negedge clk);
    a_man_ack = 1'b0;
    n_cmp++;
    if (a_madr !== 22'h00013 || a_mstb !== 1'b1) begin
      n_bad++; $display("FAIL abort_beat1: got adr=%h stb=%b want 00013 1", a_madr, a_mstb);
    end
    drop_a();
    for (int c = 3; c <= 8; c++) begin
      @(negedge clk);
      if (a_sack) acks++;
      if (a_serr) errs++;
      if (a_mcyc || a_mstb) cycs++;
    end
    n_cmp++;
    if (acks != 0 || errs != 0 || cycs != 0) begin
      n_bad++; $display("FAIL abort_quiet: got acks=%0d errs=%0d cyc_cycles=%0d want 0 0 0", acks, errs, cycs);
    end
  endtask

  task automatic test_reset_mid();
    a_auto = 1'b0; a_man_ack = 1'b0;
    req_a(21'h0000A, 32'hCAFEF00D, 4'hF, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (a_mcyc !== 1'b1 || a_mdat_o !== 16'hCAFE) begin
      n_bad++; $display("FAIL rstmid_pre: got cyc=%b dat=%h want 1 cafe", a_mcyc, a_mdat_o);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({a_sack, a_serr, a_mcyc, a_mstb, a_mwe} !== 5'b0 ||
        {a_madr, a_mdat_o, a_msel, a_sdat_o} !== 72'h0) begin
      n_bad++; $display("FAIL rstmid_async: got ctl=%b data=%h want 0 0",
                        {a_sack, a_serr, a_mcyc, a_mstb, a_mwe}, {a_madr, a_mdat_o, a_msel, a_sdat_o});
    end
    drop_a();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (a_mcyc !== 1'b0 || a_sack !== 1'b0 || a_serr !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_post: got cyc=%b ack=%b err=%b want 0 0 0", a_mcyc, a_sack, a_serr);
    end
  endtask

  task automatic test_back_to_back();
    a_auto = 1'b1;
    req_a(21'h00003, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (a_sack !== 1'b1 || a_sdat_o !== 32'h0 || a_mcyc !== 1'b0) begin
      n_bad++; $display("FAIL b2b_sel0: got ack=%b dat=%h cyc=%b want 1 0 0", a_sack, a_sdat_o, a_mcyc);
    end
    a_adr = 21'h00008; a_ssel = 4'hF;
    @(negedge clk);
    n_cmp++;
    if (a_sack !== 1'b0 || a_mcyc !== 1'b0) begin
      n_bad++; $display("FAIL b2b_idle: got ack=%b cyc=%b want 0 0", a_sack, a_mcyc);
    end
    @(negedge clk);
    n_cmp++;
    if (a_mstb !== 1'b1 || a_madr !== 22'h00010) begin
      n_bad++; $display("FAIL b2b_beat0: got stb=%b adr=%h want 1 00010", a_mstb, a_madr);
    end
    @(negedge clk);
    n_cmp++;
    if (a_madr !== 22'h00011) begin
      n_bad++; $display("FAIL b2b_beat1: got adr=%h want 00011", a_madr);
    end
    @(negedge clk);
    n_cmp++;
    if (a_sack !== 1'b1 || a_sdat_o !== 32'hABCD1234) begin
      n_bad++; $display("FAIL b2b_ack: got ack=%b dat=%h want 1 abcd1234", a_sack, a_sdat_o);
    end
    drop_a();
    @(negedge clk);
    n_cmp++;
    if (a_sack !== 1'b0) begin
      n_bad++; $display("FAIL b2b_end: got ack=%b want 0", a_sack);
    end
  endtask

  task automatic test_narrow_skip();
    b_adr = 21'h00004; b_ssel = 4'b1001; b_we = 1'b0; b_cyc = 1'b1; b_stb = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (b_madr !== 23'h000010 || b_msel !== 1'b1 || b_mstb !== 1'b1) begin
      n_bad++; $display("FAIL nar_beat0: got adr=%h sel=%b stb=%b want 000010 1 1", b_madr, b_msel, b_mstb);
    end
    @(negedge clk);
    n_cmp++;
    if (b_madr !== 23'h000013 || b_msel !== 1'b1 || b_sack !== 1'b0) begin
      n_bad++; $display("FAIL nar_beat3: got adr=%h sel=%b ack=%b want 000013 1 0", b_madr, b_msel, b_sack);
    end
    @(negedge clk);
    n_cmp++;
    if (b_sack !== 1'b1 || b_sdat_o !== 32'hAA0000BB || b_mcyc !== 1'b0) begin
      n_bad++; $display("FAIL nar_ack: got ack=%b dat=%h cyc=%b want 1 aa0000bb 0", b_sack, b_sdat_o, b_mcyc);
    end
    b_cyc = 1'b0; b_stb = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (b_sack !== 1'b0 || b_mcyc !== 1'b0) begin
      n_bad++; $display("FAIL nar_after: got ack=%b cyc=%b want 0 0", b_sack, b_mcyc);
    end
  endtask

  initial begin
    a_adr = '0; a_sdat_i = '0; a_ssel = '0; a_we = 1'b0; a_stb = 1'b0; a_cyc = 1'b0;
    a_auto = 1'b1; a_man_ack = 1'b0; a_man_dat = '0;
    b_adr = '0; b_sdat_i = '0; b_ssel = '0; b_we = 1'b0; b_stb = 1'b0; b_cyc = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_expiry_ack();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_narrow_skip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
